// File: rtl/ibuff_mac_tx_pkg.sv
// ibuff_mac_tx_pkg: shared header layout, FSM encoding and tkeep helper for the ibuff TX drain
package ibuff_mac_tx_pkg;
  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 15;
  typedef enum logic [1:0] {IDLE, HDR, WAIT, STREAM} state_e;
  function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : 8'((8'd1 << rem) - 8'd1);
  endfunction
endpackage

// File: rtl/ibuff_mac_tx_skid.sv
// axis_skid2: 2-entry skid buffer with occupancy count used as read credit
module axis_skid2
  import ibuff_mac_tx_pkg::*;
#(
  parameter int W = 73
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q, push, pop;
  logic [1:0]   cnt_q;

  assign s_ready_o = cnt_q != 2'd2;
  assign m_valid_o = cnt_q != 2'd0;
  assign m_data_o  = mem_q[rp_q];
  assign count_o   = cnt_q;
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) mem_q[wp_q] <= s_data_i;
      wp_q  <= wp_q ^ push;
      rp_q  <= rp_q ^ pop;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/ibuff_mac_tx.sv
// ibuff_mac_tx: store-and-forward drain of length-prefixed frames from ibuff to a 64-bit AXI-Stream MAC
module ibuff_mac_tx
  import ibuff_mac_tx_pkg::*;
#(
  parameter int BW      = 9,
  parameter int MAX_LEN = 1518
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW:0]   committed_prod,
  output logic [BW:0]   committed_cons,
  output logic [BW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  output logic [63:0]   m_axis_tdata,
  output logic [7:0]    m_axis_tkeep,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic          frame_drop
);
  localparam int PW = BW + 1;
  state_e      state_q, state_d;
  logic [BW:0] ptr_q, ptr_d, avail;
  logic [2:0]  rem_q, rem_d;
  logic [15:0] nqw_q, nqw_d, iss_q, iss_d, ret_q, ret_d, hdr_len, hdr_nqw;
  logic        pend_q, drop_q, drop_d, bad, room, issue, push, pop, s_ready, ret_last;
  logic [1:0]  cnt;
  logic [72:0] beat_in, beat_out;

  assign avail    = committed_prod - ptr_q;
  assign hdr_len  = rd_data[LEN_MSB:LEN_LSB];
  assign hdr_nqw  = 16'((17'(hdr_len) + 17'd7) >> 3);
  assign bad      = hdr_len == 16'd0 || 32'(hdr_len) > MAX_LEN;
  assign room     = 16'(avail) >= nqw_q + 16'd1;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign push     = pend_q && s_ready;
  // Credit counts the beat leaving the skid this cycle so a held-high tready sustains one beat per cycle
  assign issue    = (3'(pend_q) + 3'(cnt) < 3'd2 + 3'(pop)) &&
                    ((state_q == WAIT && room) || (state_q == STREAM && iss_q != nqw_q));
  assign rd_addr  = (state_q == WAIT || state_q == STREAM) ? BW'(ptr_q + PW'(iss_q) + PW'(1)) : ptr_q[BW-1:0];
  assign ret_last = (ret_q + 16'd1) == nqw_q;
  assign beat_in  = {ret_last, ret_last ? keep_from_rem(rem_q) : 8'hFF, rd_data};
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = beat_out;
  assign committed_cons = ptr_q;
  assign frame_drop     = drop_q;

  axis_skid2 #(.W(73)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (pend_q),
    .s_ready_o (s_ready),
    .s_data_i  (beat_in),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready),
    .m_data_o  (beat_out),
    .count_o   (cnt)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    nqw_d   = nqw_q;
    iss_d   = iss_q + 16'(issue);
    ret_d   = ret_q + 16'(push);
    drop_d  = 1'b0;
    case (state_q)
      IDLE: if (avail != '0) state_d = HDR;
      HDR: begin
        rem_d = hdr_len[2:0];
        nqw_d = hdr_nqw;
        iss_d = '0;
        ret_d = '0;
        if (bad) begin
          state_d = IDLE;
          ptr_d   = ptr_q + PW'(1) + PW'(hdr_nqw);
          drop_d  = 1'b1;
        end else state_d = WAIT;
      end
      WAIT: if (room) state_d = STREAM;
      default: if (pop && m_axis_tlast) begin
        state_d = IDLE;
        ptr_d   = ptr_q + PW'(1) + PW'(nqw_q);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      nqw_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      nqw_q   <= nqw_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      pend_q  <= issue;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_ibuff_mac_tx.sv
// tb_ibuff_mac_tx: directed self-checking bench for the ibuff TX drain
module tb_ibuff_mac_tx;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk, rst_n, tvalid, tlast, tready, frame_drop;
  logic [9:0]  committed_prod, committed_cons;
  logic [8:0]  rd_addr;
  logic [63:0] rd_data, tdata;
  logic [7:0]  tkeep;
  logic [63:0] mem [512];
  beat_t       exp_q [$];
  int          checks, failures, nd, nv;

  ibuff_mac_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .committed_prod (committed_prod),
    .committed_cons (committed_cons),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .m_axis_tdata   (tdata),
    .m_axis_tkeep   (tkeep),
    .m_axis_tvalid  (tvalid),
    .m_axis_tlast   (tlast),
    .m_axis_tready  (tready),
    .frame_drop     (frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cons"}, 64'(committed_cons), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(tlast), 64'd0);
    chk({tag, "_tkeep"}, 64'(tkeep), 64'd0);
    chk({tag, "_tdata"}, tdata, 64'd0);
    chk({tag, "_drop"}, 64'(frame_drop), 64'd0);
  endtask

  task automatic put_frame(input int start, input int len, input logic [7:0] lk, input bit push);
    int    n;
    beat_t b;
    n = (len + 7) / 8;
    mem[start % 512] = {48'hDEAD_BEEF_CAFE, 16'(len)};
    for (int k = 1; k <= n; k++) begin
      b.d = {16'hF00D, 16'(start), 16'(k), 16'(~k)};
      b.k = (k == n) ? lk : 8'hFF;
      b.l = (k == n);
      mem[(start + k) % 512] = b.d;
      if (push) exp_q.push_back(b);
    end
  endtask

  task automatic recv(input int n, input bit bp, input int lat, input string tag);
    int          got, cyc, first, gaps, holds;
    bit          stall;
    logic [72:0] prev;
    beat_t       e;
    got = 0; cyc = 0; first = 0; gaps = 0; holds = 0; stall = 1'b0; prev = '0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      tready = bp ? cyc[0] : 1'b1;
      if (stall && (!tvalid || {tlast, tkeep, tdata} !== prev)) holds++;
      if (first != 0 && !tvalid) gaps++;
      if (tvalid && first == 0) first = cyc;
      if (tvalid && tready) begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, tdata, e.d);
        chk({tag, "_keep"}, 64'(tkeep), 64'(e.k));
        chk({tag, "_last"}, 64'(tlast), 64'(e.l));
        got++;
      end
      stall = tvalid && !tready;
      prev  = {tlast, tkeep, tdata};
    end
    chk({tag, "_beats"}, 64'(got), 64'(n));
    chk({tag, "_gaps"}, 64'(gaps), 64'd0);
    chk({tag, "_holds"}, 64'(holds), 64'd0);
    if (lat != 0) chk({tag, "_latency"}, 64'(first), 64'(lat));
    tready = 1'b1;
  endtask

  task automatic watch(input int n, output int drops, output int valids);
    drops = 0;
    valids = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drops += int'(frame_drop);
      valids += int'(tvalid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    committed_prod = '0;
    tready = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    put_frame(0, 60, 8'h0F, 1'b1);
    committed_prod = 10'd9;
    recv(8, 1'b0, 4, "single");
    @(negedge clk);
    chk("single_cons", 64'(committed_cons), 64'd9);

    put_frame(9, 64, 8'hFF, 1'b1);
    committed_prod = 10'd18;
    recv(8, 1'b1, 4, "bp");
    @(negedge clk);
    chk("bp_cons", 64'(committed_cons), 64'd18);

    put_frame(18, 0, 8'hFF, 1'b0);
    committed_prod = 10'd19;
    watch(8, nd, nv);
    chk("drop0_pulses", 64'(nd), 64'd1);
    chk("drop0_valid", 64'(nv), 64'd0);
    chk("drop0_cons", 64'(committed_cons), 64'd19);
    put_frame(19, 2000, 8'hFF, 1'b0);
    committed_prod = 10'd270;
    watch(8, nd, nv);
    chk("drop2000_pulses", 64'(nd), 64'd1);
    chk("drop2000_valid", 64'(nv), 64'd0);
    chk("drop2000_cons", 64'(committed_cons), 64'd270);

    put_frame(270, 1500, 8'h0F, 1'b1);
    committed_prod = 10'd271;
    watch(10, nd, nv);
    chk("partial1_valid", 64'(nv), 64'd0);
    committed_prod = 10'd350;
    watch(10, nd, nv);
    chk("partial2_valid", 64'(nv), 64'd0);
    committed_prod = 10'd400;
    watch(10, nd, nv);
    chk("partial3_valid", 64'(nv), 64'd0);
    chk("partial3_cons", 64'(committed_cons), 64'd270);
    committed_prod = 10'd459;
    recv(188, 1'b0, 2, "partial");
    @(negedge clk);
    chk("partial_cons", 64'(committed_cons), 64'd459);

    put_frame(459, 384, 8'hFF, 1'b1);
    committed_prod = 10'd508;
    recv(48, 1'b0, 4, "run");
    @(negedge clk);
    chk("run_cons", 64'(committed_cons), 64'd508);

    put_frame(508, 40, 8'hFF, 1'b1);
    committed_prod = 10'd514;
    recv(5, 1'b0, 4, "wrap");
    @(negedge clk);
    chk("wrap_cons", 64'(committed_cons), 64'h202);

    put_frame(514, 64, 8'hFF, 1'b1);
    committed_prod = 10'd523;
    recv(2, 1'b0, 4, "pre_rst");
    @(negedge clk);
    tready = 1'b0;
    chk("beat3_valid", 64'(tvalid), 64'd1);
    chk("beat3_data", tdata, exp_q[0].d);
    #2;
    rst_n = 1'b0;
    committed_prod = '0;
    #1;
    chk_reset("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tready = 1'b1;
    @(negedge clk);

    put_frame(0, 13, 8'h1F, 1'b1);
    committed_prod = 10'd3;
    recv(2, 1'b0, 4, "post_rst");
    @(negedge clk);
    chk("post_rst_cons", 64'(committed_cons), 64'd3);

    watch(6, nd, nv);
    chk("tail_valid", 64'(nv), 64'd0);
    chk("tail_drops", 64'(nd), 64'd0);
    chk("tail_expq", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
